// File: rtl/awg_pkg.sv
// Shared encodings for the AWG front-panel controller: edit fields, waveforms,
// amplitude bounds, key indices and auto-repeat intervals.
package awg_pkg;

  typedef enum logic [1:0] {
    FLD_FREQ  = 2'd0,
    FLD_AMP   = 2'd1,
    FLD_PHASE = 2'd2,
    FLD_RUN   = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam logic [2:0] AMP_MIN = 3'd1;
  localparam logic [2:0] AMP_MAX = 3'd7;

  localparam int NUM_KEYS = 4;
  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_WAVE = 3;

  localparam int RPT_FIRST = 1 << 20;
  localparam int RPT_NEXT  = 1 << 18;

endpackage

// File: rtl/key_debounce.sv
// One key path: 2-flop synchroniser, stable-count debouncer and a single-cycle
// press pulse on the debounced released->pressed edge.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_raw;
  logic          w_diff;
  logic          w_done;

  assign w_raw  = ~r_sync[1];
  assign w_diff = w_raw != r_level;
  assign w_done = w_diff && (r_cnt == CW'(DB_CYCLES - 1));

  // Any cycle that agrees with the debounced level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= w_done & w_raw;
      if (w_done) begin
        r_level <= w_raw;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
endmodule

// File: rtl/awg_param_ctrl.sv
// Front-panel controller: four debounced keys drive an edit-field FSM that owns
// the generator configuration. Define AWG_AUTOREPEAT_EN for up/down hold-repeat.
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int FREQ_RESET = 64,
  parameter int FREQ_MIN   = 1,
  parameter int FREQ_MAX   = 4095,
  parameter int FREQ_STEP  = 16,
  parameter int PHASE_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  input  logic        key_wave_n,
  output logic        en,
  output logic [1:0]  wave_sel,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  edit_field
);
  logic [NUM_KEYS-1:0] w_key_n;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic                w_unused_level;
  logic [1:0]          w_rpt;

  assign w_key_n        = {key_wave_n, key_down_n, key_up_n, key_mode_n};
  assign w_unused_level = ^w_level;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key [NUM_KEYS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (w_key_n),
    .o_level (w_level),
    .o_press (w_press)
  );

`ifdef AWG_AUTOREPEAT_EN
  // A mode press kills repeat until the held key is released.
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    logic [19:0] r_cnt;
    logic        r_first;
    logic        r_kill;
    logic        r_pulse;
    logic        w_hold;
    logic [19:0] w_lim;

    assign w_hold   = w_level[KEY_UP+g] & ~r_kill & ~w_press[KEY_MODE];
    assign w_lim    = r_first ? 20'(RPT_FIRST - 1) : 20'(RPT_NEXT - 1);
    assign w_rpt[g] = r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
        r_kill  <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!w_level[KEY_UP+g])   r_kill <= 1'b0;
        else if (w_press[KEY_MODE]) r_kill <= 1'b1;
        if (!w_hold) begin
          r_cnt   <= '0;
          r_first <= 1'b1;
        end else if (r_cnt == w_lim) begin
          r_cnt   <= '0;
          r_first <= 1'b0;
          r_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end
    end
  end
`else
  assign w_rpt = 2'b00;
`endif

  logic w_mode, w_up, w_dn, w_wave;
  assign w_mode = w_press[KEY_MODE];
  assign w_up   = w_press[KEY_UP]   | w_rpt[0];
  assign w_dn   = w_press[KEY_DOWN] | w_rpt[1];
  assign w_wave = w_press[KEY_WAVE];

  field_e      r_field, w_field_nxt;
  logic        r_en, w_en_nxt;
  logic [1:0]  r_wave, w_wave_nxt;
  logic [11:0] r_freq, w_freq_nxt;
  logic [2:0]  r_amp, w_amp_nxt;
  logic [7:0]  r_phase, w_phase_nxt;
  logic [12:0] w_f13;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_field <= FLD_FREQ;
    else        r_field <= w_field_nxt;
  end

  // Field action uses the pre-advance state, so mode+up/down edits then moves on.
  always_comb begin
    w_field_nxt = r_field;
    w_en_nxt    = r_en;
    w_wave_nxt  = r_wave;
    w_freq_nxt  = r_freq;
    w_amp_nxt   = r_amp;
    w_phase_nxt = r_phase;
    w_f13       = w_up ? ({1'b0, r_freq} + 13'(FREQ_STEP))
                       : ({1'b0, r_freq} - 13'(FREQ_STEP));
    if (w_up ^ w_dn) begin
      case (r_field)
        FLD_FREQ: begin
          if (w_up)
            w_freq_nxt = (w_f13 > 13'(FREQ_MAX)) ? 12'(FREQ_MAX) : w_f13[11:0];
          else
            w_freq_nxt = (w_f13[12] || w_f13 < 13'(FREQ_MIN)) ? 12'(FREQ_MIN) : w_f13[11:0];
        end
        FLD_AMP: begin
          if (w_up) w_amp_nxt = (r_amp >= AMP_MAX) ? AMP_MAX : r_amp + 3'd1;
          else      w_amp_nxt = (r_amp <= AMP_MIN) ? AMP_MIN : r_amp - 3'd1;
        end
        FLD_PHASE: begin
          if (w_up) w_phase_nxt = r_phase + 8'(PHASE_STEP);
          else      w_phase_nxt = r_phase - 8'(PHASE_STEP);
        end
        FLD_RUN: w_en_nxt = w_up;
      endcase
    end
    if (w_wave) w_wave_nxt = r_wave + 2'd1;
    if (w_mode) begin
      case (r_field)
        FLD_FREQ:  w_field_nxt = FLD_AMP;
        FLD_AMP:   w_field_nxt = FLD_PHASE;
        FLD_PHASE: w_field_nxt = FLD_RUN;
        FLD_RUN:   w_field_nxt = FLD_FREQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_wave  <= WAVE_SINE;
      r_freq  <= 12'(FREQ_RESET);
      r_amp   <= AMP_MIN;
      r_phase <= 8'd0;
    end else begin
      r_en    <= w_en_nxt;
      r_wave  <= w_wave_nxt;
      r_freq  <= w_freq_nxt;
      r_amp   <= w_amp_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign en          = r_en;
  assign wave_sel    = r_wave;
  assign state_freq  = r_freq;
  assign state_amp   = r_amp;
  assign state_phase = r_phase;
  assign edit_field  = r_field;
endmodule

// File: tb/tb_awg_param_ctrl.sv
// Directed plus randomized key-press bench for awg_param_ctrl against a
// behavioural model of the front-panel rules.
module tb_awg_param_ctrl;
  localparam int FREQ_RESET = 64;
  localparam int FREQ_MIN   = 1;
  localparam int FREQ_MAX   = 4095;
  localparam int FREQ_STEP  = 16;
  localparam int PHASE_STEP = 8;
  // key mask bits
  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_UP   = 4'b0010;
  localparam logic [3:0] K_DN   = 4'b0100;
  localparam logic [3:0] K_WAVE = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  keys_n = 4'hF;
  logic        en;
  logic [1:0]  wave_sel;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  edit_field;

  int n_vec = 0;
  int n_err = 0;
  int m_en, m_wave, m_freq, m_amp, m_phase, m_field;

  awg_param_ctrl #(
    .DB_CYCLES(4), .FREQ_RESET(FREQ_RESET), .FREQ_MIN(FREQ_MIN),
    .FREQ_MAX(FREQ_MAX), .FREQ_STEP(FREQ_STEP), .PHASE_STEP(PHASE_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(keys_n[0]), .key_up_n(keys_n[1]),
    .key_down_n(keys_n[2]), .key_wave_n(keys_n[3]),
    .en(en), .wave_sel(wave_sel), .state_freq(state_freq),
    .state_amp(state_amp), .state_phase(state_phase), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"},    16'(en),          16'(m_en));
    chk({tag, ".wave"},  16'(wave_sel),    16'(m_wave));
    chk({tag, ".freq"},  16'(state_freq),  16'(m_freq));
    chk({tag, ".amp"},   16'(state_amp),   16'(m_amp));
    chk({tag, ".phase"}, 16'(state_phase), 16'(m_phase));
    chk({tag, ".field"}, 16'(edit_field),  16'(m_field));
  endtask

  task automatic model_reset();
    m_en = 0; m_wave = 0; m_freq = FREQ_RESET; m_amp = 1; m_phase = 0; m_field = 0;
  endtask

  // One simultaneous press of the keys in m, as the front-panel rules describe it.
  task automatic model_apply(input logic [3:0] m);
    bit up, dn;
    up = m[1]; dn = m[2];
    if (up != dn) begin
      case (m_field)
        0: m_freq  = up ? ((m_freq + FREQ_STEP > FREQ_MAX) ? FREQ_MAX : m_freq + FREQ_STEP)
                        : ((m_freq - FREQ_STEP < FREQ_MIN) ? FREQ_MIN : m_freq - FREQ_STEP);
        1: m_amp   = up ? ((m_amp < 7) ? m_amp + 1 : 7) : ((m_amp > 1) ? m_amp - 1 : 1);
        2: m_phase = (m_phase + (up ? PHASE_STEP : 256 - PHASE_STEP)) % 256;
        default: m_en = up ? 1 : 0;
      endcase
    end
    if (m[3]) m_wave = (m_wave + 1) % 4;
    if (m[0]) m_field = (m_field + 1) % 4;
  endtask

  // Press and release the keys in m together, optionally with contact bounce.
  task automatic act(input logic [3:0] m, input bit bounce);
    if (bounce) repeat (5) begin
      keys_n = ~m; cyc(2); keys_n = 4'hF; cyc(2);
    end
    keys_n = ~m;
    cyc($urandom_range(9, 14));
    keys_n = 4'hF;
    if (bounce) repeat (4) begin
      cyc(2); keys_n = ~m; cyc(2); keys_n = 4'hF;
    end
    cyc($urandom_range(9, 13));
    model_apply(m);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cyc(3);
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    cyc(2);
    check_all("after_reset");

    repeat (3) act(K_UP, 0);
    chk("freq_3up", 16'(state_freq), 16'd112);
    check_all("freq_3up");

    while (m_freq < FREQ_MAX) act(K_UP, 0);
    check_all("freq_top");
    act(K_UP, 0);
    chk("freq_sat_max", 16'(state_freq), 16'd4095);
    while (m_freq > 15) act(K_DN, 0);
    check_all("freq_15");
    act(K_DN, 0);
    chk("freq_sat_min", 16'(state_freq), 16'd1);
    act(K_DN, 0);
    check_all("freq_min_hold");

    act(K_MODE, 0);
    act(K_DN, 0);
    chk("amp_floor", 16'(state_amp), 16'd1);
    repeat (8) act(K_UP, 0);
    chk("amp_ceil", 16'(state_amp), 16'd7);
    check_all("amp");

    act(K_MODE, 0);
    act(K_DN, 0);
    chk("phase_wrap_dn", 16'(state_phase), 16'd248);
    act(K_UP, 0);
    chk("phase_wrap_up", 16'(state_phase), 16'd0);

    act(K_MODE, 0);
    act(K_UP, 0);
    chk("run_en", 16'(en), 16'd1);
    repeat (5) act(K_WAVE, 0);
    chk("wave_mod4", 16'(wave_sel), 16'd1);
    check_all("run");

    act(K_MODE, 0);
    act(K_UP, 1);
    check_all("bounce_up");
    act(K_UP | K_DN, 0);
    check_all("up_and_dn");
    act(K_MODE | K_UP, 0);
    check_all("mode_and_up");
    act(K_WAVE | K_DN | K_MODE, 0);
    check_all("wave_dn_mode");

    repeat (120) begin
      act(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      check_all("rand");
    end

    keys_n = ~K_UP;
    cyc(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid_hold");
    keys_n = 4'hF;
    cyc(3);
    rst_n = 1'b1;
    cyc(12);
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
